// File: rtl/ysyx_24110015_mem_arb_if.sv
// Bus bundle between the IFU, the LSU, the shared memory port and the arbiter.
// The master modport is the arbiter's view; slave is the surrounding cores plus memory.
interface ysyx_24110015_mem_arb_if;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_rdata;

  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
           lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_resp_ready,
           mem_req_ready, mem_resp_valid, mem_resp_err, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata,
           lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
           mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
           lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_resp_ready,
           mem_req_ready, mem_resp_valid, mem_resp_err, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata,
           lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
           mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_24110015_mem_arb.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one
// transaction in flight, with a WAIT timeout that turns into an error response.
module ysyx_24110015_mem_arb #(
  parameter int TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_24110015_mem_arb_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        owner_lsu, last_lsu;
  logic [9:0]  cnt;
  logic        wen_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wmask_q;
  logic        grant_ifu, grant_lsu, ifu_misalign, timeout;

  assign ifu_misalign = bus.ifu_addr[1:0] != 2'b00;
  // WAIT lasts TIMEOUT cycles: the last one is where cnt reaches TIMEOUT-1
  assign timeout      = cnt == 10'(TIMEOUT - 1);

  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (state == IDLE && !rst) begin
      grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu);
      grant_ifu = bus.ifu_req_valid && !grant_lsu;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_lsu)      state_nxt = REQ;
            else if (grant_ifu) state_nxt = ifu_misalign ? RESP : REQ;
      REQ:  if (bus.mem_req_ready)             state_nxt = WAIT;
      WAIT: if (bus.mem_resp_valid || timeout) state_nxt = RESP;
      RESP: if (owner_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      last_lsu  <= 1'b0;
      cnt       <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ifu || grant_lsu) begin
        owner_lsu <= grant_lsu;
        last_lsu  <= grant_lsu;
        addr_q    <= grant_lsu ? bus.lsu_addr  : bus.ifu_addr;
        wen_q     <= grant_lsu && bus.lsu_wen;
        wdata_q   <= grant_lsu ? bus.lsu_wdata : 32'h0;
        wmask_q   <= grant_lsu ? bus.lsu_wmask : 4'b0000;
        // a misaligned fetch never reaches memory; its error is known at grant
        err_q     <= grant_ifu && ifu_misalign;
        rdata_q   <= '0;
      end
      if (state == REQ)       cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 10'd1;
      if (state == WAIT) begin
        if (bus.mem_resp_valid) begin
          err_q   <= bus.mem_resp_err;
          rdata_q <= wen_q ? 32'h0 : bus.mem_rdata;
        end else if (timeout) begin
          err_q   <= 1'b1;
          rdata_q <= 32'h0;
        end
      end
    end
  end

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.mem_req_valid  = !rst && state == REQ;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign bus.ifu_resp_valid = !rst && state == RESP && !owner_lsu;
  assign bus.lsu_resp_valid = !rst && state == RESP &&  owner_lsu;
  assign bus.ifu_resp_err   = err_q;
  assign bus.ifu_rdata      = rdata_q;
  assign bus.lsu_resp_err   = err_q;
  assign bus.lsu_rdata      = rdata_q;
endmodule

// File: doc/ysyx_24110015_mem_arb.md
YSYX_24110015_MEM_ARB -- requirements
Module: ysyx_24110015_mem_arb

Interface
REQ-001 Parameter TIMEOUT, 255, max WAIT cycles before an error response; legal 1..1023.
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ifu_req_valid  in  1  fetch request valid.
REQ-005 ifu_addr  in  32  fetch address.
REQ-006 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-007 ifu_resp_valid / ifu_resp_err / ifu_rdata  out  1/1/32  fetch response, error flag, data.
REQ-008 ifu_resp_ready  in  1  IFU consumes response.
REQ-009 lsu_req_valid / lsu_wen / lsu_addr / lsu_wdata / lsu_wmask  in  1/1/32/32/4  load/store request.
REQ-010 lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-011 lsu_resp_valid / lsu_resp_err / lsu_rdata  out  1/1/32  load data or store ack.
REQ-012 lsu_resp_ready  in  1  LSU consumes response.
REQ-013 mem_req_valid / mem_wen / mem_addr / mem_wdata / mem_wmask  out  1/1/32/32/4  shared memory request.
REQ-014 mem_req_ready  in  1  memory accepts request.
REQ-015 mem_resp_valid / mem_resp_err / mem_rdata  in  1/1/32  memory response; always accepted by arbiter.

Function
REQ-016 FSM states IDLE, REQ, WAIT, RESP; one transaction outstanding at a time.
REQ-017 IDLE: if any req_valid, grant one; granted side sees req_ready=1 for exactly that cycle; request fields latched; next state REQ.
REQ-018 Arbitration round-robin: both valid -> grant side not granted last; last-grant pointer resets to IFU (LSU wins first tie).
REQ-019 Single valid requester granted regardless of pointer; pointer updates on every grant.
REQ-020 req_ready combinational from state/valids; never asserted outside IDLE; never both high.
REQ-021 IFU request with ifu_addr[1:0]!=0: granted, no memory access, straight to RESP with err=1, rdata=0.
REQ-022 IFU requests always drive mem_wen=0, mem_wmask=4'b0000.
REQ-023 REQ: mem_req_valid=1 with latched fields stable until mem_req_ready; on handshake -> WAIT, timeout counter cleared.
REQ-024 WAIT: counter increments each cycle; mem_resp_valid -> capture err/rdata into response register, -> RESP.
REQ-025 WAIT: counter == TIMEOUT with no response -> RESP with err=1, rdata=32'h0.
REQ-026 mem_resp_valid and timeout in same cycle: memory response wins, err=mem_resp_err.
REQ-027 mem_resp_valid outside WAIT ignored, no state change.
REQ-028 RESP: owner's resp_valid=1, other side's =0; err/rdata held stable until owner's resp_ready; then -> IDLE.
REQ-029 Store ack: lsu_rdata=0, err=mem_resp_err.
REQ-030 Minimum latency: grant cycle N, mem_req_valid N+1, with immediate ready and 1-cycle response resp_valid N+3.
REQ-031 Fetch response and new grant never overlap; next grant earliest cycle after resp handshake.

Reset
REQ-032 During rst: state IDLE, all *_valid and *_ready outputs 0, counter 0, pointer IFU, response/latched registers 0.
REQ-033 rst mid-transaction abandons it: mem_req_valid and resp_valid low the cycle after rst sampled; late memory response ignored.

Verification
REQ-034 Both valid after reset, mem ready and 1-cycle response -> LSU granted first, then IFU; grants alternate under continuous contention.
REQ-035 IFU addr 0x80000002 -> ifu_resp_valid with err=1, rdata=0; mem_req_valid never asserted.
REQ-036 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0011, mem_req_ready delayed 3 cycles -> mem fields stable all 4 cycles; ack err=0.
REQ-037 TIMEOUT=4, memory never responds -> resp_valid err=1 exactly 4 cycles after WAIT entry; subsequent stray mem_resp_valid ignored.
REQ-038 LSU load response 0x12345678, lsu_resp_ready low 5 cycles -> data held, no new grant, IFU req_ready stays 0.
REQ-039 rst asserted in WAIT -> all outputs 0 next cycle; following IFU fetch completes normally.
